// File: rtl/rete_totale_pkg.sv
// Shared types and helpers for the sequential Type-A/Type-B network.
package rete_totale_pkg;

  localparam int MAX_A_W = 64;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } state_e;

  function automatic int acc_width(input int w, input int n);
    return $clog2(2 * w * n + 1);
  endfunction

  // Callers zero-extend their Type-A vector to MAX_A_W bits.
  function automatic int unsigned popcount(input logic [MAX_A_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < MAX_A_W; i++) c += 32'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/rete_di_tipo_a_par.sv
// Type-A cell: expands one W-bit channel plus the feedback bit into a 2W-bit word.
module rete_di_tipo_a_par #(
  parameter int W = 4
) (
  input  logic [W-1:0]   xi,
  input  logic           b0,
  output logic [2*W-1:0] a
);

  assign a = {xi, xi[W-2:0], b0};

endmodule

// File: rtl/rete_totale_seq.sv
// Time-multiplexed Type-A stage feeding a Type-B popcount accumulator,
// driven by a level-sensitive soc/eoc handshake.
module rete_totale_seq
  import rete_totale_pkg::*;
#(
  parameter  int N     = 2,
  parameter  int W     = 4,
  localparam int ACC_W = acc_width(W, N)
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             soc,
  input  logic [N*W-1:0]   x,
  output logic             eoc,
  output logic [ACC_W-1:0] z
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [N*W-1:0]     buf_q,   buf_d;
  logic [ACC_W-1:0]   acc_q,   acc_d;
  logic [ACC_W-1:0]   z_q,     z_d;
  logic               b0_q,    b0_d;

  logic [W-1:0]       xi;
  logic [2*W-1:0]     a;
  logic [ACC_W-1:0]   sum;

  // Channel multiplexer in front of the single shared Type-A cell.
  always_comb begin
    xi = buf_q[W-1:0];
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDX_W'(i)) xi = buf_q[i*W +: W];
    end
  end

  rete_di_tipo_a_par #(.W(W)) u_tipo_a (
    .xi (xi),
    .b0 (b0_q),
    .a  (a)
  );

  assign sum = acc_q + ACC_W'(popcount(MAX_A_W'(a)));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    acc_d   = acc_q;
    z_d     = z_q;
    b0_d    = b0_q;
    unique case (state_q)
      S0: begin
        if (soc) begin
          buf_d   = x;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S1;
        end
      end
      S1: begin
        acc_d = sum;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          z_d     = sum;
          b0_d    = sum[0];
          idx_d   = '0;
          state_d = S2;
        end
      end
      S2: begin
        // A held soc parks here; only a low soc re-arms the handshake.
        if (!soc) state_d = S0;
      end
      default: state_d = S0;
    endcase
  end

  // NOTE: the capture buffer is reset along with the rest so a reset
  // mid-conversion leaves no stale channel data behind.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= S0;
      idx_q   <= '0;
      buf_q   <= '0;
      acc_q   <= '0;
      z_q     <= '0;
      b0_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      b0_q    <= b0_d;
    end
  end

  assign eoc = (state_q != S1);
  assign z   = z_q;

endmodule

// File: tb/tb_rete_totale_seq.sv
// Directed bench for rete_totale_seq (N=2 and N=3 instances) against a
// conversion-level model, checked on every falling clock edge.
module tb_rete_totale_seq;

  logic        clock = 1'b0;
  logic        reset_ = 1'b0;
  logic        soc2 = 1'b0, soc3 = 1'b0;
  logic [7:0]  x2 = '0;
  logic [11:0] x3 = '0;
  logic        eoc2, eoc3;
  logic [4:0]  z2, z3;

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 1'b0;

  always #5 clock = ~clock;

  rete_totale_seq #(.N(2), .W(4)) dut2 (
    .clock(clock), .reset_(reset_), .soc(soc2), .x(x2), .eoc(eoc2), .z(z2)
  );

  rete_totale_seq #(.N(3), .W(4)) dut3 (
    .clock(clock), .reset_(reset_), .soc(soc3), .x(x3), .eoc(eoc3), .z(z3)
  );

  // Conversion-level model: remaining channel count plus a "wait for soc low" flag.
  typedef struct packed {
    logic [31:0] busy;
    logic        wait_low;
    logic [63:0] xcap;
    logic [31:0] z;
    logic        b0;
  } mdl_t;

  mdl_t m2, m3;

  function automatic logic [31:0] conv(input logic [63:0] xv, input logic b, input int n);
    logic [31:0] total;
    logic [3:0]  xi;
    logic [7:0]  a;
    total = 0;
    for (int i = 0; i < n; i++) begin
      xi = xv[i*4 +: 4];
      a  = {xi, xi[2:0], b};
      for (int j = 0; j < 8; j++) total += 32'(a[j]);
    end
    return total;
  endfunction

  function automatic mdl_t step(input mdl_t m, input logic s, input logic [63:0] xv, input int n);
    mdl_t r;
    r = m;
    if (m.busy != 0) begin
      r.busy = m.busy - 1;
      if (r.busy == 0) begin
        r.z        = conv(m.xcap, m.b0, n);
        r.b0       = r.z[0];
        r.wait_low = 1'b1;
      end
    end else if (m.wait_low) begin
      if (!s) r.wait_low = 1'b0;
    end else if (s) begin
      r.xcap = xv;
      r.busy = n;
    end
    return r;
  endfunction

  always @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      m2 = '0;
      m3 = '0;
    end else begin
      m2 = step(m2, soc2, 64'(x2), 2);
      m3 = step(m3, soc3, 64'(x3), 3);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (checking) begin
      check("eoc2", 32'(eoc2), 32'(m2.busy == 0));
      check("z2",   32'(z2),   m2.z);
      check("eoc3", 32'(eoc3), 32'(m3.busy == 0));
      check("z3",   32'(z3),   m3.z);
    end
  end

  task automatic do_conv2(input logic [7:0] xv, input int exp_z);
    int low;
    @(negedge clock);
    x2 = xv; soc2 = 1'b1;
    @(negedge clock);
    soc2 = 1'b0;
    low = 0;
    while (eoc2 == 1'b0 && low < 20) begin
      low++;
      @(negedge clock);
    end
    check("lat2", low, 2);
    check("z2_lit", 32'(z2), exp_z);
    check("model2_lit", m2.z, exp_z);
  endtask

  task automatic do_conv3(input logic [11:0] xv, input int exp_z);
    int low;
    @(negedge clock);
    x3 = xv; soc3 = 1'b1;
    @(negedge clock);
    soc3 = 1'b0;
    low = 0;
    while (eoc3 == 1'b0 && low < 20) begin
      low++;
      @(negedge clock);
    end
    check("lat3", low, 3);
    check("z3_lit", 32'(z3), exp_z);
    check("model3_lit", m3.z, exp_z);
  endtask

  initial begin
    int low;
    repeat (2) @(negedge clock);
    check("rst_eoc2", 32'(eoc2), 1);
    check("rst_z2",   32'(z2),   0);
    reset_ = 1'b1;
    checking = 1'b1;

    do_conv2(8'hF0, 7);
    do_conv2(8'hF0, 9);
    do_conv2(8'h00, 2);
    do_conv2(8'h31, 6);
    do_conv2(8'hFF, 14);
    do_conv2(8'hFF, 14);

    // soc held high for 10 clocks: exactly one conversion.
    @(negedge clock);
    x2 = 8'h31; soc2 = 1'b1;
    low = 0;
    repeat (10) begin
      @(negedge clock);
      if (!eoc2) low++;
    end
    soc2 = 1'b0;
    check("hold_low_cycles", low, 2);
    check("hold_z", 32'(z2), 6);
    repeat (2) @(negedge clock);

    // x and soc wiggled during S1, soc left high into S2.
    x2 = 8'hF0; soc2 = 1'b1;
    @(negedge clock);
    x2 = 8'hFF; soc2 = 1'b0;
    @(negedge clock);
    x2 = 8'h00; soc2 = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("s2_eoc", 32'(eoc2), 1);
      check("s2_z", 32'(z2), 7);
    end
    soc2 = 1'b0;
    repeat (2) @(negedge clock);

    // Reset mid-S1, first without then across a clock edge.
    x2 = 8'hFF; soc2 = 1'b1;
    @(negedge clock);
    soc2 = 1'b0;
    #2 reset_ = 1'b0;
    #1;
    check("rst_mid_eoc", 32'(eoc2), 1);
    check("rst_mid_z",   32'(z2),   0);
    @(negedge clock);
    check("rst_edge_eoc", 32'(eoc2), 1);
    check("rst_edge_z",   32'(z2),   0);
    reset_ = 1'b1;
    do_conv2(8'h01, 2);

    do_conv3(12'hFFF, 21);
    do_conv3(12'hFFF, 24);

    repeat (2) @(negedge clock);
    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rete_totale_seq.md
# rete_totale_seq

Parametrised, sequential successor of the two-level Type-A/Type-B network. N input channels of W bits each feed one time-multiplexed Type-A stage. The 2W-bit Type-A outputs are reduced by a Type-B accumulator to a bit-count result. Bit 0 of the last result is fed back into the Type-A stage as b0, and the block is driven by the soc/eoc conversion handshake.

## Interface
Parameters:
- N, 2, number of input channels (N ≥ 1)
- W, 4, bits per channel (W ≥ 2)

Ports:
- clock  input  1  single system clock; all state changes on its rising edge
- reset_  input  1  asynchronous reset, active low
- soc  input  1  start of conversion, level-sensitive handshake request
- x  input  N*W  channel i occupies x[i*W+W-1 : i*W]
- eoc  output  1  end of conversion; 1 = idle, result valid
- z  output  ACC_W  result, where ACC_W = $clog2(2*W*N+1) (5 for the defaults)

## Operation
Type-A function, per channel with input nibble xi and feedback b:
- a = {xi, xi[W-2:0], b}, 2W bits wide.

Type-B function:
- The accumulator adds popcount(a) for each channel in turn.
- Width is ACC_W. The maximum value is 2*W*N, so the accumulator never overflows.

Feedback register b0:
- Set to the new z[0] on every conversion completion.
- Value 0 after reset.
- Stays constant for the whole of a conversion.

State machine (states S0, S1, S2):
- S0 (idle, eoc=1): if soc=1, capture x into an internal buffer, clear acc, set idx=0, set eoc<=0, go to S1. Otherwise stay.
- S1 (compute, eoc=0): on each edge, acc += popcount(A(buf[idx], b0)) and idx++.
- S1, edge processing idx=N-1: z <= final sum, b0 <= final sum[0], eoc <= 1, go to S2.
- S2 (done, eoc=1): wait for soc=0, then go to S0. A soc held high never retriggers a conversion.

Boundary conditions:
- x and soc changes during S1 are ignored, because the inputs are captured at the start edge.
- z holds its value across S0, S1 and S2 and changes only on the completion edge.
- N=1: S1 lasts exactly one edge.
- Reset asserted at any time, including mid-S1: immediately state=S0, eoc=1, z=0, b0=0, acc=0, idx=0. The conversion is discarded.

## Timing
- Reset values: eoc=1, z=0. Internal state: state=S0, b0=0.
- Latency: soc=1 is sampled on edge k, so eoc falls after edge k. eoc rises and z updates after edge k+N.
- Minimum handshake cycle: soc must be seen low in S2 before the next soc=1 is accepted. This gives a minimum period of N+2 clocks per conversion.
- One channel is processed per clock. There is no combinational path from soc or x to eoc or z.

## Structure
Package rete_totale_pkg contains:
- function acc_width(W, N), returning $clog2(2*W*N+1)
- typedef enum for the states S0/S1/S2
- function popcount for the 2W-bit vector

Sub-module rete_di_tipo_a_par (parameter W):
- Purely combinational: inputs xi[W-1:0] and b0, output a[2W-1:0].
- Instantiated once and shared across channels through an idx multiplexer.

The Type-B accumulator, buffer, feedback register and FSM live in rete_totale_seq.

## Test plan
Defaults (N=2, W=4) unless stated.
- Reset: assert reset_=0 mid-run, with and without a clock edge -> eoc=1, z=0 immediately. After release, the first conversion uses b0=0.
- From reset (b0=0), x=8'hF0, soc pulse -> eoc low for 2 clocks, then z=7, b0=1. Then x=8'hF0 again gives z=9 (b0 stays 1). Then x=8'h00 gives z=2 (b0 back to 0).
- b0=0, x=8'h31 -> z=6. Then x=8'hFF -> z=14. Then (b0=0) x=8'hFF again -> z=14.
- Handshake: hold soc=1 for 10 clocks -> exactly one conversion. Toggle x and soc during S1 -> z is unaffected. A soc pulse during S2 before soc returns to 0 is not accepted.
- Parameter N=3, W=4, b0=0, x=12'hFFF -> ACC_W=5, eoc low for 3 clocks, z=21, b0=1. Next x=12'hFFF -> z=24 (maximum value).
- Reset mid-S1 (after 1 of 2 channels, x=8'hFF) -> z=0, eoc=1. The next conversion of x=8'h01 yields z=2.
